// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a 3x3 window, and one
// registered result (|Gx|+|Gy| saturated, or thresholded) is produced per interior pixel.
module sobel_stream #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  input  logic             mode,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] res_out,
  output logic             res_valid,
  output logic             res_eol,
  input  logic             res_ready
);

  localparam int unsigned      GW      = PIX_W + 3;
  localparam logic [COL_W-1:0] LastCol = COL_W'(IMG_W - 1);
  localparam logic [PIX_W-1:0] PixMax  = '1;

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [1:0]       row_q, row_d, cur_row;
  logic             accept, emit;

  logic [PIX_W-1:0] line_a [IMG_W];
  logic [PIX_W-1:0] line_b [IMG_W];
  logic [PIX_W-1:0] win_q  [3][3];
  logic [PIX_W-1:0] win_d  [3][3];

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        abs_x, abs_y, mag_sum;
  logic [PIX_W-1:0]     mag, result;

  assign pix_ready = !res_valid || res_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel overrides the counters as position (0, 0).
  always_comb begin
    cur_col = pix_sof ? '0 : col_q;
    cur_row = pix_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (cur_col == LastCol) begin
        col_d = '0;
        row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  assign emit = accept && (cur_row == 2'd2) && (cur_col >= COL_W'(2));

  // Row 0 of the window is the oldest line, column 2 the newest pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = line_b[cur_col];
      win_d[1][2] = line_a[cur_col];
      win_d[2][2] = pix_in;
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  always_comb begin
    gx = (ext(win_d[0][2]) + ext(win_d[1][2]) + ext(win_d[1][2]) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + ext(win_d[1][0]) + ext(win_d[1][0]) + ext(win_d[2][0]));
    gy = (ext(win_d[2][0]) + ext(win_d[2][1]) + ext(win_d[2][1]) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + ext(win_d[0][1]) + ext(win_d[0][1]) + ext(win_d[0][2]));
    abs_x   = gx[GW-1] ? -gx : gx;
    abs_y   = gy[GW-1] ? -gy : gy;
    mag_sum = abs_x + abs_y;
    mag     = (mag_sum > {3'b000, PixMax}) ? PixMax : mag_sum[PIX_W-1:0];
    result  = mode ? ((mag >= thresh) ? PixMax : '0) : mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_eol   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      if (emit) begin
        res_valid <= 1'b1;
        res_out   <= result;
        res_eol   <= (cur_col == LastCol);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Line buffers are never cleared; row gating keeps stale contents out of results.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      line_a[cur_col] <= pix_in;
      line_b[cur_col] <= line_a[cur_col];
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Randomised bench for sobel_stream: a frame-array Sobel model predicts every result in order.
module tb_sobel_stream;
  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_ready;
  logic          mode = 1'b0;
  logic [PW-1:0] thresh = '0;
  logic [PW-1:0] res_out;
  logic          res_valid;
  logic          res_eol;
  logic          res_ready = 1'b1;

  sobel_stream #(.IMG_W(W), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .mode(mode), .thresh(thresh), .res_out(res_out),
    .res_valid(res_valid), .res_eol(res_eol), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int frame [64][W];
  int mr, mc;
  int exp_q[$];
  int got_q[$];
  int n_res, n_eol, stall_cnt;
  bit rdy_rand, accepted, held_v;
  logic [PW-1:0] held_out;
  logic held_eol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    return frame[r % 64][c];
  endfunction

  // Sobel over rows r-2..r, cols c-2..c of the frame seen so far.
  function automatic int sobel(input int r, input int c, input bit m, input int th);
    int gx, gy, mag;
    gx = (px(r-2, c) + 2*px(r-1, c) + px(r, c)) - (px(r-2, c-2) + 2*px(r-1, c-2) + px(r, c-2));
    gy = (px(r, c-2) + 2*px(r, c-1) + px(r, c)) - (px(r-2, c-2) + 2*px(r-2, c-1) + px(r-2, c));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    mag = (gx + gy > 255) ? 255 : gx + gy;
    if (m) return (mag >= th) ? 255 : 0;
    return mag;
  endfunction

  task automatic model_accept();
    if (pix_sof) begin
      mr = 0;
      mc = 0;
    end
    frame[mr % 64][mc] = int'(pix_in);
    if (mr >= 2 && mc >= 2)
      exp_q.push_back(sobel(mr, mc, mode, int'(thresh)) | ((mc == W-1) ? 256 : 0));
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
    end
  endtask

  // One clock: choose res_ready, observe at negedge, return at posedge+1.
  task automatic cycle();
    int e;
    if (stall_cnt > 0) begin
      res_ready = 1'b0;
      stall_cnt--;
    end else if (rdy_rand) res_ready = ($urandom_range(0, 3) != 0);
    else res_ready = 1'b1;
    accepted = 1'b0;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      mr = 0;
      mc = 0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", res_valid, 1);
        check("hold_out", res_out, held_out);
        check("hold_eol", res_eol, held_eol);
      end
      if (res_valid && !res_ready) check("stall_ready", pix_ready, 0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_out", res_out, e & 255);
          check("res_eol", res_eol, e >> 8);
          got_q.push_back(int'(res_out));
          n_res++;
          if (res_eol) n_eol++;
        end
      end
      if (pix_valid && pix_ready) begin
        model_accept();
        accepted = 1'b1;
      end
      held_v = res_valid && !res_ready;
      held_out = res_out;
      held_eol = res_eol;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input bit sof, input bit m, input int th);
    pix_in = PW'(p);
    pix_sof = sof;
    mode = m;
    thresh = PW'(th);
    pix_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) check("send_timeout", 0, 1);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic drain();
    pix_valid = 1'b0;
    rdy_rand = 1'b0;
    for (int k = 0; k < 60 && (exp_q.size() > 0 || res_valid); k++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_valid = 1'b0;
    cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_ready", pix_ready, 1);
    check("rst_out", res_out, 0);
    check("rst_eol", res_eol, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_scn();
    got_q.delete();
    n_res = 0;
    n_eol = 0;
  endtask

  task automatic ramp_frame(input bit m, input int th, input int exp_v, input string tag);
    start_scn();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) send(2*c, (r == 0 && c == 0), m, th);
    drain();
    check({tag, "_count"}, got_q.size(), 6);
    foreach (got_q[i]) check(tag, got_q[i], exp_v);
  endtask

  initial begin
    int step_exp[6];
    int n0;
    step_exp = '{0, 0, 255, 255, 0, 0};
    mr = 0; mc = 0; stall_cnt = 0; rdy_rand = 0; held_v = 0;

    do_reset();

    // Flat frame: 12 zero results, line ends at results 6 and 12.
    start_scn();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) send(100, (r == 0 && c == 0), 0, 0);
    drain();
    check("flat_count", n_res, 12);
    check("flat_eol", n_eol, 2);
    foreach (got_q[i]) check("flat_val", got_q[i], 0);

    // Vertical step edge with saturation.
    start_scn();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) send((c < 4) ? 0 : 255, (r == 0 && c == 0), 0, 0);
    drain();
    for (int i = 0; i < 6; i++)
      check("step_val", (i < got_q.size()) ? got_q[i] : 999, step_exp[i]);

    ramp_frame(0, 0, 16, "ramp_mag");
    ramp_frame(1, 20, 0, "ramp_th20");
    ramp_frame(1, 16, 255, "ramp_th16");

    // Backpressure: hold off the sink for 5 cycles once the first result is pending.
    start_scn();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) begin
        send(2*c, (r == 0 && c == 0), 0, 0);
        if (r == 2 && c == 2) stall_cnt = 5;
      end
    drain();
    check("bp_count", got_q.size(), 6);
    foreach (got_q[i]) check("bp_val", got_q[i], 16);

    // Start of frame in the middle of row 3.
    start_scn();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W && !(r == 3 && c == 5); c++)
        send($urandom_range(0, 255), (r == 0 && c == 0), 0, 0);
    drain();
    n0 = n_res;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) send($urandom_range(0, 255), (r == 0 && c == 0), 0, 0);
    drain();
    check("sof_count", n_res - n0, 6);

    // Reset during row 2 drops the pending result and restarts at row 0.
    start_scn();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W && !(r == 2 && c == 4); c++)
        send($urandom_range(0, 255), (r == 0 && c == 0), 0, 0);
    do_reset();
    n0 = n_res;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) send($urandom_range(0, 255), 0, 0, 0);
    drain();
    check("post_rst_none", n_res - n0, 0);
    for (int c = 0; c < W; c++) send($urandom_range(0, 255), 0, 0, 0);
    drain();
    check("post_rst_row", n_res - n0, 6);

    // Random frames, random sink readiness, idle gaps, mode and threshold.
    start_scn();
    rdy_rand = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < W; c++) begin
          if ($urandom_range(0, 4) == 0) cycle();
          send($urandom_range(0, 255), (r == 0 && c == 0), 1'($urandom_range(0, 1)),
               $urandom_range(0, 255));
        end
    drain();
    check("rand_count", n_res, 36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
